// File: rtl/icache.sv
// Direct-mapped, one-word-block, read-only instruction cache with a two-state
// refill FSM. Optional hit/miss counters are compiled in with ICACHE_STATS_EN.
module icache #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              flush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = WORD_W - IDX_W - 2;
  localparam int LINE_W = TAG_W + IDX_W;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   miss_addr_q, miss_addr_d;
  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [WORD_W-1:0]   data_q [SETS];

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic                lookup_hit;
  logic                fill;
  logic                miss_start;

  assign req_idx    = imemaddr[IDX_W+1:2];
  assign req_tag    = imemaddr[WORD_W-1:IDX_W+2];
  assign fill_idx   = miss_addr_q[IDX_W-1:0];
  assign fill_tag   = miss_addr_q[LINE_W-1:IDX_W];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill       = (state_q == FETCH) && !iwait;
  assign miss_start = nRST && (state_q == IDLE) && imemREN && !lookup_hit;

  // Byte offset within the word plays no part in the lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^imemaddr[1:0];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !lookup_hit) begin
          state_d     = FETCH;
          miss_addr_d = {req_tag, req_idx};
        end
      end
      FETCH: begin
        if (!iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even before the first edge.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (nRST) begin
      case (state_q)
        IDLE: begin
          if (imemREN && lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_q[req_idx];
          end
        end
        FETCH: begin
          iREN  = 1'b1;
          iaddr = {miss_addr_q, 2'b00};
        end
        default: ;
      endcase
    end
  end

  // Flush wins over a coinciding fill, so that fill leaves the line invalid.
  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; a line is only ever read when its valid bit is set.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (ihit && (hit_count_q != 32'hFFFF_FFFF))
        hit_count_q <= hit_count_q + 32'd1;
      if (miss_start && (miss_count_q != 32'hFFFF_FFFF))
        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
